mem_arbiter: RTL

//  Shares the single 16-bit memory port between two masters: port 0 (CPU

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single memory port. Latches the granted request,
// drives the memory bus until memory_ready (or a watchdog abort) and returns
// read data with a one-cycle ack to the granted master.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              mem_en,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              memory_ready,
    output logic              error
);

    // Watchdog only has to count up to TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t          state, state_next;
    logic            grant, grant_next;   // 0 = port 0, 1 = port 1
    logic            last_grant;
    logic [WD_W-1:0] watchdog;
    logic            timeout_hit;
    logic [DATA_W-1:0] captured;

    assign timeout_hit = (watchdog == WD_W'(TIMEOUT - 1));
    // An aborted access returns zero data.
    assign captured    = memory_ready ? mem_rdata : '0;

    // Next-state and grant decision.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_next = state;
        grant_next = grant;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    grant_next = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
                    state_next = ACCESS;
                end else if (m0_req) begin
                    grant_next = 1'b0;
                    state_next = ACCESS;
                end else if (m1_req) begin
                    grant_next = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (memory_ready || timeout_hit) state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and grant register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    // Registered memory bus, responses, watchdog and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_w      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            watchdog   <= '0;
            error      <= 1'b0;
            last_grant <= 1'b1;   // port 0 wins the first tie
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (state_next == ACCESS) begin
                        mem_en    <= 1'b1;
                        mem_w     <= grant_next ? m1_we    : m0_we;
                        mem_addr  <= grant_next ? m1_addr  : m0_addr;
                        mem_wdata <= grant_next ? m1_wdata : m0_wdata;
                        watchdog  <= '0;
                    end
                end
                ACCESS: begin
                    if (memory_ready || timeout_hit) begin
                        mem_en <= 1'b0;
                        mem_w  <= 1'b0;
                        if (!memory_ready) error <= 1'b1;
                        if (grant) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= captured;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= captured;
                        end
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                RESP: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule
